// File: rtl/vga_rx.sv
// vga_rx: DE-based video capture with a two-stage pipeline (input registers, output registers).
// Tracks frames via vsync leading edges and lines via data-enable edges. It reports
// pixel position, start-of-frame and end-of-line markers, and measured line and frame sizes.
// Optional format check: define VGA_RX_FMT_CHECK_EN to build the fmt_err logic
// (otherwise fmt_err is tied low).
module vga_rx #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  input  logic [23:0] rgb_in,
  output logic        pix_valid,
  output logic [23:0] rgb_out,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        sof,
  output logic        eol,
  output logic        frame_done,
  output logic [10:0] h_meas,
  output logic [10:0] v_meas,
  output logic        fmt_err
);

  typedef enum logic [1:0] {StIdle, StVblank, StActive} state_e;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7ff) ? v : v + 11'd1;
  endfunction

  // Stage 1 registers
  logic        hs_q, vs_q, de_q;
  logic [23:0] rgb_q;
  logic        vs_act_prev_q, de_eff_prev_q;

  state_e      state_q, state_d;
  logic [10:0] x_cnt_q, y_cnt_q;

  logic vs_act, vs_lead, de_eff, de_rise, de_fall, next_de_eff;
  logic accept, line_close, frame_end;
  logic [10:0] frame_lines;

  // hsync carries no information the line counters need; DE edges delimit lines.
  logic unused_hsync;
  assign unused_hsync = hs_q;

  assign vs_act  = (vs_q == SYNC_POL);
  assign vs_lead = vs_act & ~vs_act_prev_q;
  // DE is only meaningful outside vertical sync.
  assign de_eff  = de_q & ~vs_act;
  assign de_rise = de_eff & ~de_eff_prev_q;
  assign de_fall = ~de_eff & de_eff_prev_q;
  // Lookahead: the raw input is the successor of the pixel now in stage 1.
  assign next_de_eff = de & (vsync != SYNC_POL);
  // A line still open at vsync is closed and counted with the frame.
  assign frame_lines = de_eff_prev_q ? sat_inc(y_cnt_q) : y_cnt_q;

  // Stage 1: register all inputs and keep previous sync/enable levels for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      vs_act_prev_q <= 1'b0;
      de_eff_prev_q <= 1'b0;
    end else begin
      hs_q          <= hsync;
      vs_q          <= vsync;
      de_q          <= de;
      rgb_q         <= rgb_in;
      vs_act_prev_q <= vs_act;
      de_eff_prev_q <= de_eff;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (vs_lead) state_d = StVblank;
      StVblank: if (!vs_lead && de_rise) state_d = StActive;
      StActive: if (vs_lead) state_d = StVblank;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: pixel acceptance, line close and frame end strobes
  always_comb begin
    accept     = 1'b0;
    line_close = 1'b0;
    frame_end  = 1'b0;
    unique case (state_q)
      StVblank: accept = de_rise;
      StActive: begin
        accept     = de_eff;
        line_close = de_fall & ~vs_lead;
        frame_end  = vs_lead;
      end
      default: ;
    endcase
  end

  // Position counters for the pixel currently in stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else if (vs_lead) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else if (accept) begin
      x_cnt_q <= sat_inc(x_cnt_q);
    end else if (line_close) begin
      x_cnt_q <= '0;
      y_cnt_q <= sat_inc(y_cnt_q);
    end
  end

  // Stage 2: registered pixel outputs; rgb/position hold when nothing is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      rgb_out   <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else begin
      pix_valid <= accept;
      sof       <= 1'b0;
      eol       <= 1'b0;
      if (accept) begin
        rgb_out <= rgb_q;
        pix_x   <= x_cnt_q;
        pix_y   <= y_cnt_q;
        sof     <= (x_cnt_q == '0) && (y_cnt_q == '0);
        eol     <= ~next_de_eff;
      end
    end
  end

  // Stage 2: frame strobe and line/frame measurements
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      h_meas     <= '0;
      v_meas     <= '0;
    end else begin
      frame_done <= frame_end;
      if (line_close || (frame_end && de_eff_prev_q)) begin
        h_meas <= x_cnt_q;
      end
      if (frame_end) begin
        v_meas <= frame_lines;
      end
    end
  end

`ifdef VGA_RX_FMT_CHECK_EN
  localparam logic [10:0] HActW = 11'(H_ACTIVE);
  localparam logic [10:0] VActW = 11'(V_ACTIVE);

  logic line_bad_q, fmt_err_q;
  logic open_bad;

  assign open_bad = de_eff_prev_q && (x_cnt_q != HActW);

  // Accumulate line-length errors over a frame; publish and clear at frame boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_bad_q <= 1'b0;
      fmt_err_q  <= 1'b0;
    end else begin
      if (frame_end) begin
        fmt_err_q <= line_bad_q | open_bad | (frame_lines != VActW);
      end
      if (vs_lead) begin
        line_bad_q <= 1'b0;
      end else if (line_close && (x_cnt_q != HActW)) begin
        line_bad_q <= 1'b1;
      end
    end
  end

  assign fmt_err = fmt_err_q;
`else
  // Expected dimensions only matter to the format check.
  logic unused_cfg;
  assign unused_cfg = (H_ACTIVE == 0) ^ (V_ACTIVE == 0);
  assign fmt_err    = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: directed scenarios on a small 8x4 raster with a ramp pixel source.
module tb_vga_rx;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int HB   = 4;
  localparam int LINE = H + HB;
`ifdef VGA_RX_FMT_CHECK_EN
  localparam bit FMT_ON = 1'b1;
`else
  localparam bit FMT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        hsync, vsync, de;
  logic [23:0] rgb_in;
  logic        pix_valid, sof, eol, frame_done, fmt_err;
  logic [23:0] rgb_out;
  logic [10:0] pix_x, pix_y, h_meas, v_meas;

  int total = 0;
  int bad   = 0;

  logic [23:0] ramp = 24'd0;
  // Expectation for the item driven one step earlier (visible after two edges)
  bit          p_acc = 1'b0, p_sof = 1'b0, p_eol = 1'b0, p_fd = 1'b0;
  logic [23:0] p_rgb = '0;
  logic [10:0] p_x = '0, p_y = '0;
  logic [23:0] last_rgb = '0;

  vga_rx #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .SYNC_POL(1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .rgb_in    (rgb_in),
    .pix_valid (pix_valid),
    .rgb_out   (rgb_out),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .sof       (sof),
    .eol       (eol),
    .frame_done(frame_done),
    .h_meas    (h_meas),
    .v_meas    (v_meas),
    .fmt_err   (fmt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, then check the outputs produced by the previous cycle's item.
  task automatic step(input bit vs_on, input bit de_v, input bit acc, input int x, input int y,
                      input bit is_eol, input bit fd);
    logic [23:0] cur;
    cur    = de_v ? ramp : ~ramp;
    vsync  = vs_on ? 1'b0 : 1'b1;
    hsync  = de_v;
    de     = de_v;
    rgb_in = cur;
    if (de_v) ramp = ramp + 24'd1;
    tick;
    total++;
    if (pix_valid !== p_acc) begin
      bad++;
      $display("FAIL pix_valid t=%0t got=%b exp=%b", $time, pix_valid, p_acc);
    end
    total++;
    if (frame_done !== p_fd) begin
      bad++;
      $display("FAIL frame_done t=%0t got=%b exp=%b", $time, frame_done, p_fd);
    end
    total++;
    if (sof !== (p_acc & p_sof)) begin
      bad++;
      $display("FAIL sof t=%0t got=%b exp=%b", $time, sof, p_acc & p_sof);
    end
    total++;
    if (eol !== (p_acc & p_eol)) begin
      bad++;
      $display("FAIL eol t=%0t got=%b exp=%b", $time, eol, p_acc & p_eol);
    end
    total++;
    if (rgb_out !== (p_acc ? p_rgb : last_rgb)) begin
      bad++;
      $display("FAIL rgb_out t=%0t got=%h exp=%h", $time, rgb_out, p_acc ? p_rgb : last_rgb);
    end
    if (p_acc) begin
      total++;
      if (pix_x !== p_x) begin
        bad++;
        $display("FAIL pix_x t=%0t got=%0d exp=%0d", $time, pix_x, p_x);
      end
      total++;
      if (pix_y !== p_y) begin
        bad++;
        $display("FAIL pix_y t=%0t got=%0d exp=%0d", $time, pix_y, p_y);
      end
      last_rgb = p_rgb;
    end
    p_acc = acc;
    p_sof = (x == 0) && (y == 0);
    p_eol = is_eol;
    p_fd  = fd;
    p_rgb = cur;
    p_x   = 11'(x);
    p_y   = 11'(y);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic pulse_reset;
    rst_n = 1'b0;
    #1;
    total++;
    if ({pix_valid, rgb_out, pix_x, pix_y, sof, eol, frame_done, h_meas, v_meas, fmt_err}
        !== '0) begin
      bad++;
      $display("FAIL async_reset got valid=%b rgb=%h x=%0d y=%0d h=%0d v=%0d exp all zero",
               pix_valid, rgb_out, pix_x, pix_y, h_meas, v_meas);
    end
    #2 rst_n = 1'b1;
    p_acc    = 1'b0;
    p_fd     = 1'b0;
    last_rgb = '0;
  endtask

  // One vsync line (DE held high for the first cycles, always ignored) plus one back-porch line.
  task automatic send_vsync(input bit fd_exp);
    for (int i = 0; i < LINE; i++) step(1'b1, i < 4, 1'b0, 0, 0, 1'b0, fd_exp && (i == 0));
    for (int i = 0; i < LINE; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Active lines plus one front-porch line; optional short line, vsync cut, or reset point.
  task automatic send_active(input bit cap, input int short_y, input int cut_y, input int cut_x,
                             input int rst_y, input int rst_x);
    bit c;
    int len;
    bit last;
    c = cap;
    for (int y = 0; y < V; y++) begin
      len = (y == short_y) ? H - 1 : H;
      for (int x = 0; x < len; x++) begin
        if ((y == rst_y) && (x == rst_x)) begin
          pulse_reset;
          c = 1'b0;
        end
        last = (x == len - 1) || ((y == cut_y) && (x == cut_x));
        step(1'b0, 1'b1, c, x, y, last, 1'b0);
        if ((y == cut_y) && (x == cut_x)) return;
      end
      for (int i = 0; i < HB; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    end
    for (int i = 0; i < LINE; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    repeat (3) tick;
    total++;
    if ({pix_valid, rgb_out, pix_x, pix_y, sof, eol, frame_done, h_meas, v_meas, fmt_err}
        !== '0) begin
      bad++;
      $display("FAIL reset_state got valid=%b rgb=%h h=%0d v=%0d exp all zero",
               pix_valid, rgb_out, h_meas, v_meas);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_no_pix_before_vsync;
    send_active(1'b0, -1, -1, -1, -1, -1);
    total++;
    if ({h_meas, v_meas} !== 22'd0) begin
      bad++;
      $display("FAIL idle_meas got h=%0d v=%0d exp h=0 v=0", h_meas, v_meas);
    end
  endtask

  task automatic test_full_frames;
    send_vsync(1'b0);
    send_active(1'b1, -1, -1, -1, -1, -1);
    send_vsync(1'b1);
    total++;
    if (h_meas !== 11'd8) begin
      bad++;
      $display("FAIL full_h_meas got=%0d exp=8", h_meas);
    end
    total++;
    if (v_meas !== 11'd4) begin
      bad++;
      $display("FAIL full_v_meas got=%0d exp=4", v_meas);
    end
    total++;
    if (fmt_err !== 1'b0) begin
      bad++;
      $display("FAIL full_fmt_err got=%b exp=0", fmt_err);
    end
    send_active(1'b1, -1, -1, -1, -1, -1);
  endtask

  task automatic test_short_line;
    send_vsync(1'b1);
    send_active(1'b1, 2, -1, -1, -1, -1);
    send_vsync(1'b1);
    total++;
    if (fmt_err !== FMT_ON) begin
      bad++;
      $display("FAIL short_fmt_err got=%b exp=%b", fmt_err, FMT_ON);
    end
    total++;
    if ({h_meas, v_meas} !== {11'd8, 11'd4}) begin
      bad++;
      $display("FAIL short_meas got h=%0d v=%0d exp h=8 v=4", h_meas, v_meas);
    end
    send_active(1'b1, -1, -1, -1, -1, -1);
    send_vsync(1'b1);
    total++;
    if (fmt_err !== 1'b0) begin
      bad++;
      $display("FAIL clean_fmt_err got=%b exp=0", fmt_err);
    end
  endtask

  task automatic test_vsync_cut;
    send_active(1'b1, -1, 1, 5, -1, -1);
    send_vsync(1'b1);
    total++;
    if (v_meas !== 11'd2) begin
      bad++;
      $display("FAIL cut_v_meas got=%0d exp=2", v_meas);
    end
    total++;
    if (h_meas !== 11'd6) begin
      bad++;
      $display("FAIL cut_h_meas got=%0d exp=6", h_meas);
    end
    total++;
    if (fmt_err !== FMT_ON) begin
      bad++;
      $display("FAIL cut_fmt_err got=%b exp=%b", fmt_err, FMT_ON);
    end
    send_active(1'b1, -1, -1, -1, -1, -1);
    send_vsync(1'b1);
    total++;
    if ({v_meas, fmt_err} !== {11'd4, 1'b0}) begin
      bad++;
      $display("FAIL recover_meas got v=%0d fmt=%b exp v=4 fmt=0", v_meas, fmt_err);
    end
  endtask

  task automatic test_reset_mid_frame;
    send_active(1'b1, -1, -1, -1, 2, 4);
    total++;
    if ({h_meas, v_meas, fmt_err} !== 23'd0) begin
      bad++;
      $display("FAIL post_reset_meas got h=%0d v=%0d fmt=%b exp all zero",
               h_meas, v_meas, fmt_err);
    end
    send_vsync(1'b0);
    send_active(1'b1, -1, -1, -1, -1, -1);
    send_vsync(1'b1);
    total++;
    if ({h_meas, v_meas} !== {11'd8, 11'd4}) begin
      bad++;
      $display("FAIL resume_meas got h=%0d v=%0d exp h=8 v=4", h_meas, v_meas);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    hsync  = 1'b1;
    vsync  = 1'b1;
    de     = 1'b0;
    rgb_in = '0;
    test_reset;
    test_no_pix_before_vsync;
    test_full_frames;
    test_short_line;
    test_vsync_cut;
    test_reset_mid_frame;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
